// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and feeds
// the IF/ID register, with a one-entry hold buffer for responses that land during a stall.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        PCSel,
  input  logic [31:0] pc_target,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic [31:0] pcPlus4_out,
  output logic        valid_out
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [29:0] r_pc_word;
  logic [31:0] r_hold_inst;
  logic [29:0] r_hold_pc_word;
  logic [31:0] r_inst;
  logic [31:0] r_pc_out;
  logic [31:0] r_pc4_out;
  logic        r_valid;

  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_hold_pc;
  logic        w_accept;
  logic        w_unused_target_bits;

  // PC is kept word-aligned by construction, so imem_addr[1:0] is always zero.
  assign w_pc       = {r_pc_word, 2'b00};
  assign w_pc_plus4 = {r_pc_word + 30'd1, 2'b00};
  assign w_hold_pc  = {r_hold_pc_word, 2'b00};
  assign w_accept   = (r_state == ST_FETCH) && imem_ready;

  assign w_unused_target_bits = &{1'b0, pc_target[1:0]};

  assign imem_req    = (r_state == ST_FETCH);
  assign imem_addr   = w_pc;
  assign inst        = r_inst;
  assign pc_out      = r_pc_out;
  assign pcPlus4_out = r_pc4_out;
  assign valid_out   = r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_FETCH;
      r_pc_word      <= RESET_PC[31:2];
      r_hold_inst    <= NOP_INST;
      r_hold_pc_word <= 30'd0;
      r_inst         <= NOP_INST;
      r_pc_out       <= 32'd0;
      r_pc4_out      <= 32'd0;
      r_valid        <= 1'b0;
    end else if (PCSel) begin
      // Redirect drops any in-flight or buffered instruction; pc_out keeps its last value.
      r_state        <= ST_FETCH;
      r_pc_word      <= pc_target[31:2];
      r_hold_inst    <= NOP_INST;
      r_hold_pc_word <= 30'd0;
      r_inst         <= NOP_INST;
      r_valid        <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_accept) begin
            r_pc_word <= r_pc_word + 30'd1;
            if (!stall) begin
              r_inst    <= imem_rdata;
              r_pc_out  <= w_pc;
              r_pc4_out <= w_pc_plus4;
              r_valid   <= 1'b1;
            end else begin
              r_hold_inst    <= imem_rdata;
              r_hold_pc_word <= r_pc_word;
              r_state        <= ST_HOLD;
              if (flush) begin
                r_inst  <= NOP_INST;
                r_valid <= 1'b0;
              end
            end
          end else if (!stall || flush) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            r_inst    <= r_hold_inst;
            r_pc_out  <= w_hold_pc;
            r_pc4_out <= {r_hold_pc_word + 30'd1, 2'b00};
            r_valid   <= 1'b1;
            r_state   <= ST_FETCH;
          end else if (flush) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule
